// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with a registered one-cycle lookup, 2-bit direction
// counters, round-robin replacement and a sweep FSM that invalidates the table.
module btb_assoc #(
    parameter int unsigned SET_BITS = 6,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned TAG_BITS = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    output logic        busy_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_valid_o,
    output logic        pred_hit_o,
    output logic        pred_taken_o,
    output logic [1:0]  pred_ctr_o,
    output logic [31:0] pred_pc_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic [31:0] upd_tpc_i,
    input  logic        upd_taken_i
);
    localparam int unsigned Sets    = 1 << SET_BITS;
    localparam int unsigned WayBits = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [31:0] UsedMask = ((32'd1 << (TAG_BITS + SET_BITS)) - 32'd1) << 2;

    localparam logic StInit = 1'b0;
    localparam logic StRun  = 1'b1;

    logic                state_q, state_d;
    logic [SET_BITS-1:0] sweep_cnt_q, sweep_cnt_d;

    logic                valid_q [Sets][WAYS];
    logic [TAG_BITS-1:0] tag_q   [Sets][WAYS];
    logic [31:0]         tgt_q   [Sets][WAYS];
    logic [1:0]          ctr_q   [Sets][WAYS];
    logic [WayBits-1:0]  vic_q   [Sets];

    logic        pred_valid_q, pred_hit_q, pred_taken_q;
    logic [1:0]  pred_ctr_q;
    logic [31:0] pred_pc_q;

    function automatic logic [SET_BITS-1:0] idx_f(input logic [31:0] pc);
        return pc[2 +: SET_BITS] ^ pc[2+SET_BITS +: SET_BITS];
    endfunction

    logic                lk_en, up_en;
    logic [SET_BITS-1:0] f_idx, u_idx;
    logic [TAG_BITS-1:0] f_tag, u_tag;

    assign lk_en = (state_q == StRun) && fetch_valid_i;
    // An update coinciding with a flush is dropped; the table is about to be cleared anyway.
    assign up_en = (state_q == StRun) && upd_valid_i && !flush_i;
    assign f_idx = idx_f(fetch_pc_i);
    assign u_idx = idx_f(upd_pc_i);
    assign f_tag = fetch_pc_i[2+SET_BITS +: TAG_BITS];
    assign u_tag = upd_pc_i[2+SET_BITS +: TAG_BITS];

    logic        lk_hit;
    logic [1:0]  lk_ctr;
    logic [31:0] lk_tgt;

    always_comb begin
        lk_hit = 1'b0;
        lk_ctr = 2'b00;
        lk_tgt = 32'd0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
                lk_hit = 1'b1;
                lk_ctr = ctr_q[f_idx][w];
                lk_tgt = tgt_q[f_idx][w];
            end
        end
    end

    logic               u_hit, u_free;
    logic [WayBits-1:0] u_way, u_free_way, alloc_way, vic_nxt;
    logic [1:0]         u_ctr, ctr_nxt;

    always_comb begin
        u_hit      = 1'b0;
        u_way      = '0;
        u_ctr      = 2'b00;
        u_free     = 1'b0;
        u_free_way = '0;
        // Descending scan so the lowest-index invalid way wins.
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!valid_q[u_idx][w]) begin
                u_free     = 1'b1;
                u_free_way = WayBits'(w);
            end
        end
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
                u_hit = 1'b1;
                u_way = WayBits'(w);
                u_ctr = ctr_q[u_idx][w];
            end
        end
    end

    assign alloc_way = u_free ? u_free_way : vic_q[u_idx];
    assign vic_nxt   = (WAYS == 1) ? '0 : vic_q[u_idx] + WayBits'(1);
    assign ctr_nxt   = upd_taken_i ? ((u_ctr == 2'b11) ? 2'b11 : u_ctr + 2'b01)
                                   : ((u_ctr == 2'b00) ? 2'b00 : u_ctr - 2'b01);

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        if (state_q == StInit) begin
            if (flush_i) begin
                sweep_cnt_d = '0;
            end else begin
                sweep_cnt_d = sweep_cnt_q + SET_BITS'(1);
                if (&sweep_cnt_q) begin
                    state_d = StRun;
                end
            end
        end else if (flush_i) begin
            state_d     = StInit;
            sweep_cnt_d = '0;
        end
    end

    // Table storage needs no reset: the sweep clears the valid bits before any use.
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                valid_q[sweep_cnt_q][w] <= 1'b0;
            end
            vic_q[sweep_cnt_q] <= '0;
        end else if (up_en) begin
            if (u_hit) begin
                ctr_q[u_idx][u_way] <= ctr_nxt;
                if (upd_taken_i) begin
                    tgt_q[u_idx][u_way] <= upd_tpc_i;
                end
            end else if (upd_taken_i) begin
                valid_q[u_idx][alloc_way] <= 1'b1;
                tag_q[u_idx][alloc_way]   <= u_tag;
                tgt_q[u_idx][alloc_way]   <= upd_tpc_i;
                ctr_q[u_idx][alloc_way]   <= 2'b10;
                if (!u_free) begin
                    vic_q[u_idx] <= vic_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StInit;
            sweep_cnt_q  <= '0;
            pred_valid_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ctr_q   <= 2'b00;
            pred_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            pred_valid_q <= lk_en;
            if (lk_en) begin
                pred_hit_q   <= lk_hit;
                pred_taken_q <= lk_hit & lk_ctr[1];
                pred_ctr_q   <= lk_ctr;
                pred_pc_q    <= (lk_hit && lk_ctr[1]) ? lk_tgt : fetch_pc_i + 32'd4;
            end
        end
    end

    logic upd_pc_unused;
    assign upd_pc_unused = ^(upd_pc_i & ~UsedMask);

    assign busy_o       = (state_q == StInit);
    assign pred_valid_o = pred_valid_q;
    assign pred_hit_o   = pred_hit_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_ctr_o   = pred_ctr_q;
    assign pred_pc_o    = pred_pc_q;
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SET_BITS=6, WAYS=2, TAG_BITS=12): vector table plus
// hand sequences for reset, flush, sweep restart and read-old behaviour.
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = 32'd0;
    logic        pred_valid, pred_hit, pred_taken;
    logic [1:0]  pred_ctr;
    logic [31:0] pred_pc;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic [31:0] upd_tpc = 32'd0;
    logic        upd_taken = 1'b0;

    int errors = 0;
    int checks = 0;

    btb_assoc #(.SET_BITS(6), .WAYS(2), .TAG_BITS(12)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .busy_o(busy),
        .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc),
        .pred_valid_o(pred_valid), .pred_hit_o(pred_hit), .pred_taken_o(pred_taken),
        .pred_ctr_o(pred_ctr), .pred_pc_o(pred_pc),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_tpc_i(upd_tpc),
        .upd_taken_i(upd_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_upd;
        logic [31:0] pc;
        logic [31:0] tpc;
        logic        taken;
        logic        eh;
        logic [1:0]  ec;
        logic [31:0] epc;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_u(input logic [31:0] pc, input logic [31:0] tpc, input logic tk);
        vec_t v;
        v.is_upd = 1'b1; v.pc = pc; v.tpc = tpc; v.taken = tk;
        v.eh = 1'b0; v.ec = 2'b00; v.epc = 32'd0; v.name = "upd";
        vecs.push_back(v);
    endtask

    task automatic add_l(input logic [31:0] pc, input logic eh, input logic [1:0] ec,
                         input logic [31:0] epc, input string nm);
        vec_t v;
        v.is_upd = 1'b0; v.pc = pc; v.tpc = 32'd0; v.taken = 1'b0;
        v.eh = eh; v.ec = ec; v.epc = epc; v.name = nm;
        vecs.push_back(v);
    endtask

    // All tasks start and end at #1 after a rising edge.
    task automatic do_upd(input logic [31:0] pc, input logic [31:0] tpc, input logic tk);
        upd_valid = 1'b1; upd_pc = pc; upd_tpc = tpc; upd_taken = tk;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic eh, input logic [1:0] ec,
                          input logic [31:0] epc, input string nm);
        fetch_valid = 1'b1; fetch_pc = pc;
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        chk({nm, " valid"}, 32'(pred_valid), 32'd1);
        chk({nm, " hit"},   32'(pred_hit),   32'(eh));
        chk({nm, " taken"}, 32'(pred_taken), 32'(eh & ec[1]));
        chk({nm, " ctr"},   32'(pred_ctr),   32'(ec));
        chk({nm, " pc"},    pred_pc,         epc);
    endtask

    task automatic count_busy(input int start, input int exp, input string nm);
        int n = start;
        while (busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " busy cycles"}, 32'(n), 32'(exp));
    endtask

    initial begin
        // Index of 0x1000/0x11000/0x21000/0x31000 is 0x10 for all; tags differ.
        add_l(32'h0000_1000, 1'b0, 2'b00, 32'h0000_1004, "empty 1000");
        add_u(32'h0000_1000, 32'h0000_2000, 1'b1);
        add_l(32'h0000_1000, 1'b1, 2'b10, 32'h0000_2000, "alloc 1000");
        add_u(32'h0000_1000, 32'h0000_2000, 1'b1);
        add_u(32'h0000_1000, 32'h0000_2000, 1'b1);
        add_l(32'h0000_1000, 1'b1, 2'b11, 32'h0000_2000, "sat up");
        add_u(32'h0000_1000, 32'h0000_2000, 1'b0);
        add_u(32'h0000_1000, 32'h0000_2000, 1'b0);
        add_u(32'h0000_1000, 32'h0000_2000, 1'b0);
        add_l(32'h0000_1000, 1'b1, 2'b00, 32'h0000_1004, "sat down");
        add_u(32'h0000_1000, 32'h0000_2000, 1'b0);
        add_l(32'h0000_1000, 1'b1, 2'b00, 32'h0000_1004, "stay 00");
        add_u(32'h0001_1000, 32'h0000_3000, 1'b1);
        add_u(32'h0002_1000, 32'h0000_4000, 1'b1);
        add_l(32'h0000_1000, 1'b0, 2'b00, 32'h0000_1004, "evicted A");
        add_l(32'h0001_1000, 1'b1, 2'b10, 32'h0000_3000, "way1 B");
        add_l(32'h0002_1000, 1'b1, 2'b10, 32'h0000_4000, "way0 C");
        add_u(32'h0003_1000, 32'h0000_5000, 1'b1);
        add_l(32'h0001_1000, 1'b0, 2'b00, 32'h0001_1004, "evicted B");
        add_l(32'h0002_1000, 1'b1, 2'b10, 32'h0000_4000, "kept C");
        add_l(32'hFFFF_FFFC, 1'b0, 2'b00, 32'h0000_0000, "wrap");
        add_u(32'h0000_7000, 32'h0000_8000, 1'b0);
        add_l(32'h0000_7000, 1'b0, 2'b00, 32'h0000_7004, "nt absent");
        add_l(32'h0003_1000, 1'b1, 2'b10, 32'h0000_5000, "way1 D");

        #1 rst = 1'b1;
        #2;
        chk("rst busy",       32'(busy),       32'd1);
        chk("rst pred_valid", 32'(pred_valid), 32'd0);
        chk("rst pred_hit",   32'(pred_hit),   32'd0);
        chk("rst pred_taken", 32'(pred_taken), 32'd0);
        chk("rst pred_ctr",   32'(pred_ctr),   32'd0);
        chk("rst pred_pc",    pred_pc,         32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Lookup and update during the sweep are ignored.
        fetch_valid = 1'b1; fetch_pc = 32'h0000_1000;
        upd_valid = 1'b1; upd_pc = 32'h0000_1000; upd_tpc = 32'h0000_9000; upd_taken = 1'b1;
        @(posedge clk); #1;
        fetch_valid = 1'b0; upd_valid = 1'b0;
        chk("init pred_valid", 32'(pred_valid), 32'd0);
        count_busy(1, 64, "reset");

        foreach (vecs[i]) begin
            if (vecs[i].is_upd) do_upd(vecs[i].pc, vecs[i].tpc, vecs[i].taken);
            else lookup(vecs[i].pc, vecs[i].eh, vecs[i].ec, vecs[i].epc, vecs[i].name);
        end

        @(posedge clk); #1;
        chk("idle pred_valid", 32'(pred_valid), 32'd0);
        chk("idle pc hold",    pred_pc,         32'h0000_5000);

        // Flush with a same-cycle lookup: lookup still sees the old contents.
        flush = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h0002_1000;
        @(posedge clk); #1;
        flush = 1'b0; fetch_valid = 1'b0;
        chk("flush lk hit", 32'(pred_hit), 32'd1);
        chk("flush lk pc",  pred_pc,       32'h0000_4000);
        chk("flush busy",   32'(busy),     32'd1);
        repeat (10) @(posedge clk);
        #1;
        do_upd(32'h0000_A000, 32'h0000_B000, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        count_busy(0, 64, "reflush");

        lookup(32'h0002_1000, 1'b0, 2'b00, 32'h0002_1004, "post flush C");
        lookup(32'h0003_1000, 1'b0, 2'b00, 32'h0003_1004, "post flush D");
        lookup(32'h0000_A000, 1'b0, 2'b00, 32'h0000_A004, "busy upd drop");

        // Same-cycle update and lookup: read-old, then visible next cycle.
        fetch_valid = 1'b1; fetch_pc = 32'h0000_1000;
        upd_valid = 1'b1; upd_pc = 32'h0000_1000; upd_tpc = 32'h0000_2000; upd_taken = 1'b1;
        @(posedge clk); #1;
        fetch_valid = 1'b0; upd_valid = 1'b0;
        chk("same cyc hit", 32'(pred_hit), 32'd0);
        chk("same cyc pc",  pred_pc,       32'h0000_1004);
        lookup(32'h0000_1000, 1'b1, 2'b10, 32'h0000_2000, "next cyc");

        // Mid-operation reset.
        rst = 1'b1;
        #1;
        chk("midrst busy",  32'(busy),       32'd1);
        chk("midrst valid", 32'(pred_valid), 32'd0);
        chk("midrst pc",    pred_pc,         32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(0, 64, "midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
